id_ex_hazard_stage: RTL
=======================

Name: id_ex_hazard_stage

Overview:
- Decode→execute pipeline register of the vector ASIP, plus load-use hazard detection.
- Captures the decoded operands, register addresses, ExtndSel and VF, and presents them to the forwarding unit and execute stage one cycle later.
- Inserts bubbles and stalls fetch/decode when a memory load in execute feeds the instruction in decode, since the forwarding paths cannot cover that case.
- Honours branch flush and downstream hold.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 4, register address width
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
valid_d  in  1  decode holds a real instruction
r2_data_d, r3_data_d  in  DATA_W  register-file read data
r2_addr_d, r3_addr_d  in  REG_AW  source register addresses
dest_d  in  REG_AW  destination register
extnd_sel_d  in  2  operand-usage select (bit1: R2 used; 2'b10: R2 and R3 used)
vf_d  in  1  vector flag
wr_en_d  in  1  writes register file
mem_read_d  in  1  instruction is a load
flush  in  1  branch taken in execute; kill decode→execute transfer
ex_hold  in  1  execute busy (multi-cycle vector op); freeze this stage
valid_e, r2_data_e, r3_data_e, r2_addr_e, r3_addr_e, dest_e, extnd_sel_e, vf_e, wr_en_e, mem_read_e  out  as inputs  registered copies
stall_fd  out  1  hold PC and fetch/decode registers this cycle

Behaviour:
- Reset (async, rst=1): all *_e outputs are 0 and the FSM is in RUN with the bubble counter at 0.
- stall_fd is combinational and 0 while rst is asserted.
- Source usage:
  - r2_used = extnd_sel_d[1].
  - r3_used = extnd_sel_d==2'b10.
  - Register address 0 never creates a hazard.
- Hazard: haz = valid_d & valid_e & mem_read_e & ((r2_used & r2_addr_d!=0 & r2_addr_d==dest_e) | (r3_used & r3_addr_d!=0 & r3_addr_d==dest_e)).
- Bubble value: valid, wr_en, mem_read, extnd_sel and dest are all 0. The data, address and vf fields are don't-care but are driven to 0.
- FSM states:
  - RUN:
    - If haz and neither flush nor ex_hold: load a bubble, stall_fd=1, cnt<=LOAD_BUBBLES-1, and go to STALL if cnt would be >0, else stay in RUN.
    - Otherwise load the decode fields and set stall_fd=0.
  - STALL: stall_fd=1, load a bubble, cnt<=cnt-1, and return to RUN when cnt reaches 0. This holds because the load has left execute and the hazard is now covered by writeback forwarding.
- Priority per edge: flush > ex_hold > hazard/STALL > normal load.
  - flush: the register loads a bubble, the FSM goes to RUN, cnt=0, stall_fd=0 (fetch redirects).
  - ex_hold (and no flush): all *_e fields hold, FSM and cnt are frozen, stall_fd=1.
- Simultaneous flush and ex_hold: flush wins and the bubble is loaded.
- Latency: 1 cycle from decode input to *_e output when there is no stall.
- No combinational path from any *_d input to any *_e output.
- Reset mid-stall aborts the stall immediately. The decode instruction is lost; fetch restarts from the reset vector.

Decomposition:
- Shared package pipe_pkg holds:
  - ext_sel_t enum (EXT_NONE=2'b00, EXT_R2=2'b11, EXT_R2R3=2'b10)
  - stage_state_t {RUN, STALL}
  - id_ex_t packed struct bundling every *_d/*_e field
  - BUBBLE constant of type id_ex_t
- One natural sub-module: load_use_detect (combinational haz equation), reusable by a later EX/MEM stage.

Test Plan:
- Reset: assert rst mid-cycle with valid_d=1 → all *_e are 0 immediately and stall_fd=0. After release, the next edge loads r2_data_d=32'hAABBCCDD into r2_data_e.
- Load-use on R2: execute holds a load with dest_e=4'h3; decode has r2_addr_d=3, extnd_sel_d=2'b11 → stall_fd=1 for 1 cycle and valid_e=0 for 1 cycle. The instruction then enters with r2_addr_e=3.
- R3 ignored: same as the R2 case but with r3_addr_d=3 and extnd_sel_d=2'b11 → no stall. With extnd_sel_d=2'b10 → 1-cycle stall.
- Register zero: load with dest_e=0 and r2_addr_d=0 → no stall.
- LOAD_BUBBLES=2: R2 hazard → stall_fd high 2 cycles and two consecutive bubbles. Asserting flush during the second stall cycle → RUN immediately, stall_fd=0, bubble loaded.
- ex_hold: hold asserted 3 cycles with changing *_d → *_e stable and stall_fd=1. flush together with ex_hold → bubble loaded.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared decode/execute pipeline types: operand-usage select, stage FSM
// states and the ID/EX register payload with its bubble value.
package pipe_pkg;

    localparam int DATA_W_P = 32;
    localparam int REG_AW_P = 4;

    typedef enum logic [1:0] {
        EXT_NONE = 2'b00,
        EXT_R2   = 2'b11,
        EXT_R2R3 = 2'b10
    } ext_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stage_state_t;

    typedef struct packed {
        logic                valid;
        logic [DATA_W_P-1:0] r2_data;
        logic [DATA_W_P-1:0] r3_data;
        logic [REG_AW_P-1:0] r2_addr;
        logic [REG_AW_P-1:0] r3_addr;
        logic [REG_AW_P-1:0] dest;
        ext_sel_t            extnd_sel;
        logic                vf;
        logic                wr_en;
        logic                mem_read;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '0;

    function automatic logic r2_used(input logic [1:0] sel);
        return sel[1];
    endfunction

    function automatic logic r3_used(input logic [1:0] sel);
        return sel == 2'b10;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check: a load in execute whose destination feeds a used,
// non-zero source register of the instruction in decode.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_P
) (
    input  logic              valid_d,
    input  logic [REG_AW-1:0] r2_addr_d,
    input  logic [REG_AW-1:0] r3_addr_d,
    input  logic [1:0]        extnd_sel_d,
    input  logic              valid_e,
    input  logic              mem_read_e,
    input  logic [REG_AW-1:0] dest_e,
    output logic              haz
);

    logic r2_hit;
    logic r3_hit;

    always_comb begin
        r2_hit = r2_used(extnd_sel_d) && (r2_addr_d != '0) && (r2_addr_d == dest_e);
        r3_hit = r3_used(extnd_sel_d) && (r3_addr_d != '0) && (r3_addr_d == dest_e);
        haz    = valid_d && valid_e && mem_read_e && (r2_hit || r3_hit);
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// Decode->execute pipeline register with load-use bubble insertion,
// branch flush and execute-hold freeze.
module id_ex_hazard_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W       = DATA_W_P,
    parameter int REG_AW       = REG_AW_P,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [DATA_W-1:0] r2_data_d,
    input  logic [DATA_W-1:0] r3_data_d,
    input  logic [REG_AW-1:0] r2_addr_d,
    input  logic [REG_AW-1:0] r3_addr_d,
    input  logic [REG_AW-1:0] dest_d,
    input  logic [1:0]        extnd_sel_d,
    input  logic              vf_d,
    input  logic              wr_en_d,
    input  logic              mem_read_d,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              valid_e,
    output logic [DATA_W-1:0] r2_data_e,
    output logic [DATA_W-1:0] r3_data_e,
    output logic [REG_AW-1:0] r2_addr_e,
    output logic [REG_AW-1:0] r3_addr_e,
    output logic [REG_AW-1:0] dest_e,
    output logic [1:0]        extnd_sel_e,
    output logic              vf_e,
    output logic              wr_en_e,
    output logic              mem_read_e,
    output logic              stall_fd
);

    localparam logic [1:0] CNT_INIT = 2'(LOAD_BUBBLES - 1);

    id_ex_t       ex_q, ex_d, dec;
    stage_state_t state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         haz;
    logic         stall_raw;

    load_use_detect #(.REG_AW(REG_AW)) u_detect (
        .valid_d     (valid_d),
        .r2_addr_d   (r2_addr_d),
        .r3_addr_d   (r3_addr_d),
        .extnd_sel_d (extnd_sel_d),
        .valid_e     (ex_q.valid),
        .mem_read_e  (ex_q.mem_read),
        .dest_e      (ex_q.dest),
        .haz         (haz)
    );

    always_comb begin
        dec.valid     = valid_d;
        dec.r2_data   = r2_data_d;
        dec.r3_data   = r3_data_d;
        dec.r2_addr   = r2_addr_d;
        dec.r3_addr   = r3_addr_d;
        dec.dest      = dest_d;
        dec.extnd_sel = ext_sel_t'(extnd_sel_d);
        dec.vf        = vf_d;
        dec.wr_en     = wr_en_d;
        dec.mem_read  = mem_read_d;
    end

    // Priority: flush > ex_hold > pending bubbles / new hazard > normal load.
    always_comb begin
        ex_d      = ex_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        if (flush) begin
            ex_d    = BUBBLE;
            state_d = RUN;
            cnt_d   = '0;
        end else if (ex_hold) begin
            stall_raw = 1'b1;
        end else if (state_q == STALL) begin
            ex_d      = BUBBLE;
            stall_raw = 1'b1;
            cnt_d     = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = RUN;
        end else if (haz) begin
            ex_d      = BUBBLE;
            stall_raw = 1'b1;
            cnt_d     = CNT_INIT;
            state_d   = (CNT_INIT != 2'd0) ? STALL : RUN;
        end else begin
            ex_d = dec;
        end
    end

    assign stall_fd = stall_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= BUBBLE;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_e     = ex_q.valid;
    assign r2_data_e   = ex_q.r2_data;
    assign r3_data_e   = ex_q.r3_data;
    assign r2_addr_e   = ex_q.r2_addr;
    assign r3_addr_e   = ex_q.r3_addr;
    assign dest_e      = ex_q.dest;
    assign extnd_sel_e = ex_q.extnd_sel;
    assign vf_e        = ex_q.vf;
    assign wr_en_e     = ex_q.wr_en;
    assign mem_read_e  = ex_q.mem_read;

endmodule
